shift_stage: RTL and testbench
==============================

SHIFT_STAGE -- requirements
Module: shift_stage

Interface
REQ-001 Parameter: DEPTH, default 2, request queue entries (power of two, 2..8).
REQ-002 Port: clk  in  1  sole clock; all state changes on rising edge.
REQ-003 Port: reset  in  1  synchronous reset, active-high.
REQ-004 Port: req_valid  in  1  request present; req_ready  out  1  queue can accept.
REQ-005 Port: req_data  in  16  operand; req_amt  in  8  shift amount; req_mode  in  3  shifter mode code.
REQ-006 Port: sh_in  out  16, sh_n  out  4, sh_mode  out  3  drive the downstream combinational shifter; sh_out  in  16  shifter result.
REQ-007 Port: res_valid  out  1, res_ready  in  1  result handshake.
REQ-008 Port: res_data  out  16, res_carry  out  1, res_zero  out  1  registered result and flags.
REQ-009 Port: busy  out  1  high when the queue or result register holds anything.

Function
REQ-010 Mode codes: 000/100 pass, 001 LSR, 010 ASR, 011 ROR, 101/110 LSL, 111 ROL.
REQ-011 Request accepted on an edge where req_valid && req_ready; req_ready = queue not full; data/amt/mode written to tail.
REQ-012 Queue is FIFO; pointers wrap modulo DEPTH; accept and issue on the same edge when full keep count at DEPTH and keep req_ready low during that cycle.
REQ-013 sh_in/sh_mode = head entry; sh_n = amt[3:0] for shift/rotate modes, 0 for pass; outputs are 0 when the queue is empty.
REQ-014 Issue occurs on an edge where queue non-empty and (res_valid low or res_ready high); head popped, result register loaded the same edge.
REQ-015 Latency: request accepted on edge E with empty pipeline -> res_valid high after edge E+1; one result per cycle sustained under no backpressure.
REQ-016 res_data = sh_out for pass, rotates, and amt <= 15.
REQ-017 LSR/LSL with amt >= 16: res_data = 0, shifter output ignored.
REQ-018 ASR with amt >= 16: res_data = 16 copies of data[15].
REQ-019 Rotates use amt mod 16; amt 16 behaves as amt 0.
REQ-020 Carry, amt 0 or pass: 0; LSR/ASR 1..15: data[amt-1]; LSL 1..15: data[16-amt]; ROR nonzero: res_data[15]; ROL nonzero: res_data[0].
REQ-021 Carry, amt >= 16: LSR amt==16 -> data[15], LSL amt==16 -> data[0], LSR/LSL amt>16 -> 0, ASR -> data[15].
REQ-022 res_zero = (res_data == 0), registered with res_data.
REQ-023 res_valid held with res_data/flags stable until res_ready sampled high; drained with no issue -> res_valid low next cycle.
REQ-024 Requests never dropped, reordered, or duplicated under any valid/ready pattern.

Reset
REQ-025 Reset clears queue pointers/count, res_valid, res_data, res_carry, res_zero to 0; req_ready high and busy low the cycle after reset.
REQ-026 Reset asserted mid-operation discards queued and pending results; handshakes during the reset cycle are ignored.

Verification
REQ-027 Push data=8001h, amt=4, mode=001, res_ready=1 -> res_data=0800h, carry=0, zero=0 after edge E+1.
REQ-028 data=8001h, amt=1, mode=010 -> res_data=C000h, carry=1; amt=20 same mode -> FFFFh, carry=1.
REQ-029 data=8001h, amt=16, mode=101 -> res_data=0000h, carry=1, zero=1; amt=17 -> 0000h, carry=0.
REQ-030 data=8001h, mode=011, amt=1 -> C000h, carry=1; mode=111, amt=17 -> 0003h, carry=1.
REQ-031 res_ready=0, push DEPTH+1 requests -> req_ready low after DEPTH+1 accepted (DEPTH queued + 1 result); release -> results in order, one per cycle.
REQ-032 Reset with full queue and res_valid high -> next cycle res_valid=0, busy=0, req_ready=1; no stale results emerge.

Source files
------------

// File: rtl/shift_stage_if.sv
// Bundle of request, shifter-side and result handshake signals for shift_stage.
// The slave modport is the stage itself; the master modport is its environment.
interface shift_stage_if;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_data;
    logic [7:0]  req_amt;
    logic [2:0]  req_mode;

    logic [15:0] sh_in;
    logic [3:0]  sh_n;
    logic [2:0]  sh_mode;
    logic [15:0] sh_out;

    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic        res_carry;
    logic        res_zero;
    logic        busy;

    modport slave (
        input  req_valid, req_data, req_amt, req_mode, sh_out, res_ready,
        output req_ready, sh_in, sh_n, sh_mode, res_valid, res_data, res_carry, res_zero, busy
    );

    modport master (
        output req_valid, req_data, req_amt, req_mode, sh_out, res_ready,
        input  req_ready, sh_in, sh_n, sh_mode, res_valid, res_data, res_carry, res_zero, busy
    );
endinterface

// File: rtl/shift_stage.sv
// Queued shift/rotate stage: FIFO of requests feeds an external combinational shifter,
// the result is patched for out-of-range shift amounts and registered with carry/zero flags.
module shift_stage #(
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          reset,
    shift_stage_if.slave  bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic [2:0] {OP_PASS, OP_LSR, OP_ASR, OP_ROR, OP_LSL, OP_ROL} op_e;

    function automatic op_e decode(input logic [2:0] m);
        case (m)
            3'b001:         return OP_LSR;
            3'b010:         return OP_ASR;
            3'b011:         return OP_ROR;
            3'b101, 3'b110: return OP_LSL;
            3'b111:         return OP_ROL;
            default:        return OP_PASS;
        endcase
    endfunction

    // The shifter only sees amt[3:0]; logical/arithmetic shifts of 16 or more are resolved here.
    function automatic logic [15:0] fix_result(input logic [15:0] d, input logic [7:0] amt,
                                               input op_e op, input logic [15:0] sh);
        logic big;
        big = (amt[7:4] != 4'd0);
        case (op)
            OP_LSR, OP_LSL: return big ? 16'd0 : sh;
            OP_ASR:         return big ? {16{d[15]}} : sh;
            default:        return sh;
        endcase
    endfunction

    function automatic logic calc_carry(input logic [15:0] d, input logic [7:0] amt,
                                        input op_e op, input logic [15:0] r);
        logic [3:0] n;
        logic       big;
        logic       at16;
        n    = amt[3:0];
        big  = (amt[7:4] != 4'd0);
        at16 = (amt == 8'd16);
        case (op)
            OP_LSR:  return big ? (at16 & d[15]) : ((n != 4'd0) & d[n - 4'd1]);
            OP_ASR:  return big ? d[15] : ((n != 4'd0) & d[n - 4'd1]);
            OP_LSL:  return big ? (at16 & d[0]) : ((n != 4'd0) & d[4'd0 - n]);
            OP_ROR:  return (n != 4'd0) & r[15];
            OP_ROL:  return (n != 4'd0) & r[0];
            default: return 1'b0;
        endcase
    endfunction

    logic [15:0]   data_mem_q [DEPTH];
    logic [7:0]    amt_mem_q  [DEPTH];
    logic [2:0]    mode_mem_q [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          res_valid_q, res_valid_d;
    logic [15:0]   res_data_q, res_data_d;
    logic          res_carry_q, res_carry_d;
    logic          res_zero_q, res_zero_d;

    logic          empty, full, accept, issue;
    logic [15:0]   head_data;
    logic [7:0]    head_amt;
    logic [2:0]    head_mode;
    op_e           head_op;

    assign empty     = (count_q == '0);
    assign full      = (count_q == CW'(DEPTH));
    assign accept    = bus.req_valid && !full;
    assign issue     = !empty && (!res_valid_q || bus.res_ready);
    assign head_data = data_mem_q[rd_ptr_q];
    assign head_amt  = amt_mem_q[rd_ptr_q];
    assign head_mode = mode_mem_q[rd_ptr_q];
    assign head_op   = decode(head_mode);

    assign bus.sh_in   = empty ? 16'd0 : head_data;
    assign bus.sh_mode = empty ? 3'd0 : head_mode;
    assign bus.sh_n    = (empty || head_op == OP_PASS) ? 4'd0 : head_amt[3:0];

    always_comb begin
        wr_ptr_d    = accept ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d    = issue ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d     = count_q;
        if (accept && !issue) count_d = count_q + CW'(1);
        if (!accept && issue) count_d = count_q - CW'(1);

        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_carry_d = res_carry_q;
        res_zero_d  = res_zero_q;
        if (issue) begin
            res_valid_d = 1'b1;
            res_data_d  = fix_result(head_data, head_amt, head_op, bus.sh_out);
            res_carry_d = calc_carry(head_data, head_amt, head_op, res_data_d);
            res_zero_d  = (res_data_d == 16'd0);
        end else if (bus.res_ready) begin
            res_valid_d = 1'b0;
        end
    end

    // Reset drops every handshake seen in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= 16'd0;
            res_carry_q <= 1'b0;
            res_zero_q  <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_carry_q <= res_carry_d;
            res_zero_q  <= res_zero_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && accept) begin
            data_mem_q[wr_ptr_q] <= bus.req_data;
            amt_mem_q[wr_ptr_q]  <= bus.req_amt;
            mode_mem_q[wr_ptr_q] <= bus.req_mode;
        end
    end

    assign bus.req_ready = !full;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_carry = res_carry_q;
    assign bus.res_zero  = res_zero_q;
    assign bus.busy      = !empty || res_valid_q;
endmodule

// File: tb/tb_shift_stage.sv
// Bench for shift_stage: models the external shifter, predicts results from the mode rules
// and compares them in order through a scoreboard fed at request acceptance.
module tb_shift_stage;
    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    shift_stage_if bus();
    shift_stage #(.DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

    int checks = 0;
    int failures = 0;

    logic [17:0] sb[$];
    logic        stall = 1'b0;
    logic [17:0] held;
    logic [31:0] rot_t;

    // Downstream combinational shifter seen by the stage.
    always_comb begin
        rot_t      = {bus.sh_in, bus.sh_in};
        bus.sh_out = bus.sh_in;
        case (bus.sh_mode)
            3'b001: bus.sh_out = bus.sh_in >> bus.sh_n;
            3'b010: bus.sh_out = $unsigned($signed(bus.sh_in) >>> bus.sh_n);
            3'b011: begin rot_t = rot_t >> bus.sh_n; bus.sh_out = rot_t[15:0]; end
            3'b101, 3'b110: bus.sh_out = bus.sh_in << bus.sh_n;
            3'b111: begin rot_t = rot_t << bus.sh_n; bus.sh_out = rot_t[31:16]; end
            default: bus.sh_out = bus.sh_in;
        endcase
    end

    // Returns {zero, carry, data}: the bit last shifted out is found by shifting one place less.
    function automatic logic [17:0] ref_model(input logic [15:0] d, input logic [7:0] amt,
                                              input logic [2:0] mode);
        logic [63:0]        x, x2;
        logic signed [63:0] s, s2;
        logic [31:0]        dd;
        logic [15:0]        r;
        logic               c;
        int                 k;
        x  = {48'd0, d};
        s  = $signed({{48{d[15]}}, d});
        dd = {d, d};
        k  = int'(amt) % 16;
        r  = d;
        c  = 1'b0;
        case (mode)
            3'b001: begin
                x2 = x >> amt; r = x2[15:0];
                if (amt != 0) begin x2 = x >> (amt - 8'd1); c = x2[0]; end
            end
            3'b010: begin
                s2 = s >>> amt; r = s2[15:0];
                if (amt != 0) begin s2 = s >>> (amt - 8'd1); c = s2[0]; end
            end
            3'b011: begin dd = dd >> k; r = dd[15:0]; c = (k != 0) && r[15]; end
            3'b101, 3'b110: begin
                x2 = x << amt; r = x2[15:0];
                c = (amt != 0) && x2[16];
            end
            3'b111: begin dd = dd << k; r = dd[31:16]; c = (k != 0) && r[0]; end
            default: begin r = d; c = 1'b0; end
        endcase
        return {(r == 16'd0), c, r};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: checks state first, then records the handshakes about to complete.
    always @(negedge clk) begin
        int occ;
        if (reset) begin
            sb.delete();
            stall = 1'b0;
        end else begin
            if (stall) begin
                chk("hold_valid", 32'(bus.res_valid), 32'd1);
                chk("hold_result", 32'({bus.res_zero, bus.res_carry, bus.res_data}), 32'(held));
            end
            occ = sb.size() - int'(bus.res_valid);
            chk("req_ready", 32'(bus.req_ready), 32'(occ != DEPTH));
            chk("busy", 32'(bus.busy), 32'(sb.size() != 0));
            if (occ == 0) chk("sh_idle", {9'd0, bus.sh_in, bus.sh_n, bus.sh_mode}, 32'd0);
            if (bus.res_valid && bus.res_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_result: got %0h expected none at %0t",
                             {bus.res_zero, bus.res_carry, bus.res_data}, $time);
                end else begin
                    chk("result", 32'({bus.res_zero, bus.res_carry, bus.res_data}),
                        32'(sb.pop_front()));
                end
            end
            stall = bus.res_valid && !bus.res_ready;
            held  = {bus.res_zero, bus.res_carry, bus.res_data};
            if (bus.req_valid && bus.req_ready)
                sb.push_back(ref_model(bus.req_data, bus.req_amt, bus.req_mode));
        end
    end

    task automatic directed(input logic [15:0] d, input logic [7:0] a, input logic [2:0] m,
                            input logic [15:0] ed, input logic ec, input logic ez);
        bus.req_valid = 1'b1;
        bus.req_data  = d;
        bus.req_amt   = a;
        bus.req_mode  = m;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        chk("lat_edge0", 32'(bus.res_valid), 32'd0);
        @(posedge clk); #1;
        chk("lat_edge1", 32'(bus.res_valid), 32'd1);
        chk("dir_data", 32'(bus.res_data), 32'(ed));
        chk("dir_carry", 32'(bus.res_carry), 32'(ec));
        chk("dir_zero", 32'(bus.res_zero), 32'(ez));
        @(posedge clk); #1;
    endtask

    task automatic fill_stalled(input int cycles, output int accepted);
        accepted = 0;
        bus.res_ready = 1'b0;
        bus.req_valid = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            bus.req_data = 16'($urandom);
            bus.req_amt  = 8'($urandom_range(0, 20));
            bus.req_mode = 3'($urandom);
            @(negedge clk);
            if (bus.req_ready) accepted++;
            @(posedge clk); #1;
        end
        bus.req_valid = 1'b0;
    endtask

    initial begin
        int acc;
        int n;
        reset = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_data  = 16'd0;
        bus.req_amt   = 8'd0;
        bus.req_mode  = 3'd0;
        bus.res_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
        chk("rst_flags", 32'({bus.res_zero, bus.res_carry, bus.res_data}), 32'd0);

        bus.res_ready = 1'b1;
        directed(16'h8001, 8'd4,  3'b001, 16'h0800, 1'b0, 1'b0);
        directed(16'h8001, 8'd1,  3'b010, 16'hC000, 1'b1, 1'b0);
        directed(16'h8001, 8'd20, 3'b010, 16'hFFFF, 1'b1, 1'b0);
        directed(16'h8001, 8'd16, 3'b101, 16'h0000, 1'b1, 1'b1);
        directed(16'h8001, 8'd17, 3'b101, 16'h0000, 1'b0, 1'b1);
        directed(16'h8001, 8'd1,  3'b011, 16'hC000, 1'b1, 1'b0);
        directed(16'h8001, 8'd17, 3'b111, 16'h0003, 1'b1, 1'b0);
        directed(16'h8001, 8'd16, 3'b001, 16'h0000, 1'b1, 1'b1);
        directed(16'h1234, 8'd5,  3'b100, 16'h1234, 1'b0, 1'b0);
        directed(16'h8001, 8'd16, 3'b111, 16'h8001, 1'b0, 1'b0);

        // Backpressure: DEPTH queued plus one held in the result register.
        fill_stalled(DEPTH + 4, acc);
        chk("bp_accepted", 32'(acc), 32'(DEPTH + 1));
        chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
        bus.res_ready = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) begin
            chk("bp_stream_valid", 32'(bus.res_valid), 32'd1);
            @(posedge clk); #1;
        end
        chk("bp_drained", 32'(bus.res_valid), 32'd0);

        // Reset with a full queue and a pending result; handshakes in that cycle are ignored.
        fill_stalled(DEPTH + 3, acc);
        chk("pre_rst_busy", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        bus.req_valid = 1'b1;
        bus.res_ready = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        bus.req_valid = 1'b0;
        chk("mid_rst_res_valid", 32'(bus.res_valid), 32'd0);
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        chk("mid_rst_req_ready", 32'(bus.req_ready), 32'd1);
        repeat (5) @(posedge clk);
        #1 chk("no_stale", 32'(bus.res_valid), 32'd0);

        for (int cyc = 0; cyc < 2000; cyc++) begin
            bus.req_valid = ($urandom_range(0, 9) < 6);
            bus.res_ready = ($urandom_range(0, 9) < 7);
            bus.req_data  = 16'($urandom);
            bus.req_mode  = 3'($urandom);
            case ($urandom_range(0, 3))
                0: bus.req_amt = 8'($urandom_range(0, 15));
                1: bus.req_amt = 8'($urandom_range(15, 17));
                2: bus.req_amt = 8'($urandom);
                default: bus.req_amt = 8'($urandom_range(16, 31));
            endcase
            reset = (cyc == 1000);
            @(posedge clk); #1;
        end
        reset = 1'b0;
        bus.req_valid = 1'b0;
        bus.res_ready = 1'b1;
        n = 0;
        while (bus.busy && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
